// File: rtl/sd_block_buffer_if.sv
// Host request, host buffer port and sd_card_controller-facing signals of sd_block_buffer.
// master = host logic plus controller, slave = the block buffer.
interface sd_block_buffer_if #(
  parameter int unsigned PTR_W = 9
);
  logic             host_rd_req;
  logic             host_wr_req;
  logic [31:0]      host_addr;
  logic             host_busy;
  logic             host_done;
  logic             host_error;
  logic [PTR_W-1:0] buf_addr;
  logic [7:0]       buf_wdata;
  logic             buf_we;
  logic [7:0]       buf_rdata;
  logic             ctrl_execute;
  logic             ctrl_op_code;
  logic [31:0]      ctrl_block_address;
  logic [7:0]       ctrl_outgoing_byte;
  logic [7:0]       ctrl_incoming_byte;
  logic             ctrl_finished_byte;
  logic             ctrl_finished_block;
  logic             ctrl_busy;

  modport master (
    output host_rd_req, host_wr_req, host_addr, buf_addr, buf_wdata, buf_we,
    output ctrl_incoming_byte, ctrl_finished_byte, ctrl_finished_block, ctrl_busy,
    input  host_busy, host_done, host_error, buf_rdata,
    input  ctrl_execute, ctrl_op_code, ctrl_block_address, ctrl_outgoing_byte
  );

  modport slave (
    input  host_rd_req, host_wr_req, host_addr, buf_addr, buf_wdata, buf_we,
    input  ctrl_incoming_byte, ctrl_finished_byte, ctrl_finished_block, ctrl_busy,
    output host_busy, host_done, host_error, buf_rdata,
    output ctrl_execute, ctrl_op_code, ctrl_block_address, ctrl_outgoing_byte
  );
endinterface

// File: rtl/sd_block_buffer.sv
// One-block sector buffer: host byte port on a single RAM, plus the sequencer that drives
// sd_card_controller for block reads (stream into RAM) and writes (stream out of RAM).
module sd_block_buffer #(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned PTR_W       = 9
) (
  input logic              clk,
  input logic              btn,
  sd_block_buffer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StWaitCtrl, StPrefetch, StIssue, StXfer, StDone
  } state_e;

  localparam logic [PTR_W:0] BlockCnt = (PTR_W+1)'(BLOCK_BYTES);

  state_e           state_q, state_d;
  logic [PTR_W:0]   ptr_q, ptr_d;
  logic             ovf_q, ovf_d;
  logic             op_q, pf_q, fetch_q, fetch_d;
  logic             err_q, done_q, err_out_q;
  logic [31:0]      addr_q;
  logic [7:0]       out_q, rd_q;
  logic [7:0]       mem [BLOCK_BYTES];
  logic             accept, ptr_full, byte_evt, ram_we;
  logic [PTR_W-1:0] ram_waddr, rd_addr;
  logic [7:0]       ram_wdata;
  logic             execute, busy;

  assign accept   = (state_q == StIdle) && (bus.host_rd_req || bus.host_wr_req);
  assign ptr_full = (ptr_q == BlockCnt);
  assign byte_evt = (state_q == StXfer) && bus.ctrl_finished_byte;

  always_ff @(posedge clk) begin
    if (btn) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept) state_d = StWaitCtrl;
      StWaitCtrl: if (!bus.ctrl_busy) state_d = op_q ? StPrefetch : StIssue;
      StPrefetch: if (pf_q) state_d = StIssue;
      StIssue:    state_d = StXfer;
      StXfer:     if (bus.ctrl_finished_block) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    execute = (state_q == StIssue);
    busy    = (state_q != StIdle);
  end

  // Pointer saturates at BlockCnt; extra bytes only raise the overflow flag.
  always_comb begin
    ptr_d = ptr_q;
    ovf_d = ovf_q;
    if (accept) begin
      ptr_d = '0;
      ovf_d = 1'b0;
    end else if (byte_evt) begin
      if (ptr_full) ovf_d = 1'b1;
      else          ptr_d = ptr_q + 1'b1;
    end
  end

  assign fetch_d   = byte_evt && op_q && (ptr_d != BlockCnt);
  assign ram_we    = ((state_q == StIdle) && bus.buf_we) || (byte_evt && !op_q && !ptr_full);
  assign ram_waddr = (state_q == StXfer) ? ptr_q[PTR_W-1:0] : bus.buf_addr;
  assign ram_wdata = (state_q == StXfer) ? bus.ctrl_incoming_byte : bus.buf_wdata;
  // Write transfers steal the read port, looking one byte ahead via ptr_d.
  assign rd_addr   = (op_q && (state_q == StPrefetch || state_q == StXfer)) ?
                     ptr_d[PTR_W-1:0] : bus.buf_addr;

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (btn) rd_q <= '0;
    else     rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (btn) begin
      ptr_q     <= '0;
      ovf_q     <= 1'b0;
      op_q      <= 1'b0;
      pf_q      <= 1'b0;
      fetch_q   <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
      addr_q    <= '0;
      out_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      ovf_q     <= ovf_d;
      fetch_q   <= fetch_d;
      pf_q      <= (state_q == StPrefetch) && !pf_q;
      done_q    <= (state_q == StDone);
      err_out_q <= (state_q == StDone) && err_q;
      if (accept) begin
        addr_q <= bus.host_addr;
        op_q   <= !bus.host_rd_req;
        err_q  <= 1'b0;
      end
      if ((state_q == StXfer) && bus.ctrl_finished_block) begin
        err_q <= ovf_d || (ptr_d != BlockCnt);
      end
      if (((state_q == StPrefetch) && pf_q) || fetch_q) out_q <= rd_q;
    end
  end

  assign bus.host_busy          = busy;
  assign bus.host_done          = done_q;
  assign bus.host_error         = err_out_q;
  assign bus.buf_rdata          = rd_q;
  assign bus.ctrl_execute       = execute;
  assign bus.ctrl_op_code       = op_q;
  assign bus.ctrl_block_address = addr_q;
  assign bus.ctrl_outgoing_byte = out_q;

endmodule

// File: tb/tb_sd_block_buffer.sv
// Bench for sd_block_buffer: directed host/controller stimulus, a cycle-level transaction
// model (busy window, execute/done cycles, buffer contents) and a per-cycle compare process.
module tb_sd_block_buffer;
  localparam int unsigned BB  = 512;
  localparam int unsigned PW  = 9;
  localparam int          BIG = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic btn = 1'b1;
  always #5 clk = ~clk;

  sd_block_buffer_if #(.PTR_W(PW)) bus ();
  sd_block_buffer #(.BLOCK_BYTES(BB), .PTR_W(PW)) dut (.clk(clk), .btn(btn), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model
  int          m_from = 0, m_to = 0, m_exec_at = -1, m_done_at = -1;
  bit          m_op = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0;
  logic [7:0]  m_mem [BB];
  int          exec_cnt = 0, done_cnt = 0, err_cnt = 0;
  bit          chk_en = 1'b0;
  bit          p_valid = 1'b0, p_we = 1'b0;
  logic [PW-1:0] p_addr = '0;
  logic [7:0]  p_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit mbusy(input int c);
    return (c >= m_from) && (c < m_to);
  endfunction

  function automatic void try_accept(input int k, input bit rd, input bit wr,
                                     input logic [31:0] a, input int nb);
    int e;
    if ((rd || wr) && !mbusy(k)) begin
      m_op      = !rd;
      m_addr    = a;
      m_from    = k + 1;
      m_to      = BIG;
      m_done_at = -1;
      e = k + 2;
      if (k + nb + 1 > e) e = k + nb + 1;
      m_exec_at = e + (rd ? 0 : 2);
    end
  endfunction

  function automatic void end_block(input int f, input int n);
    m_to      = f + 2;
    m_done_at = f + 2;
    m_err     = (n != BB);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("host_busy", 32'(bus.host_busy), 32'(mbusy(cyc)));
      chk("ctrl_execute", 32'(bus.ctrl_execute), 32'(cyc == m_exec_at));
      chk("host_done", 32'(bus.host_done), 32'(cyc == m_done_at));
      if (cyc == m_done_at) chk("host_error", 32'(bus.host_error), 32'(m_err));
      if (mbusy(cyc)) begin
        chk("ctrl_op_code", 32'(bus.ctrl_op_code), 32'(m_op));
        chk("ctrl_block_address", bus.ctrl_block_address, m_addr);
      end
      if (p_valid && !mbusy(cyc - 1) && !$isunknown(m_mem[p_addr]))
        chk("buf_rdata_model", 32'(bus.buf_rdata), 32'(m_mem[p_addr]));
      if (p_valid && p_we && !mbusy(cyc - 1)) m_mem[p_addr] = p_wdata;
      if (bus.ctrl_execute === 1'b1) exec_cnt++;
      if (bus.host_done === 1'b1) done_cnt++;
      if (bus.host_done === 1'b1 && bus.host_error === 1'b1) err_cnt++;
    end
    p_valid = !btn;
    p_addr  = bus.buf_addr;
    p_we    = bus.buf_we;
    p_wdata = bus.buf_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit rd, input bit wr, input logic [31:0] a, input int nb);
    int k;
    k = cyc;
    bus.host_rd_req = rd;
    bus.host_wr_req = wr;
    bus.host_addr   = a;
    bus.ctrl_busy   = (nb > 0);
    try_accept(k, rd, wr, a, nb);
    tick();
    bus.host_rd_req = 1'b0;
    bus.host_wr_req = 1'b0;
    bus.host_addr   = 32'hDEAD_0000 | 32'(k);
    for (int j = 1; j < nb; j++) begin
      if (j == 3) begin
        bus.host_wr_req = 1'b1;
        bus.host_addr   = 32'h0BAD_0BAD;
        try_accept(cyc, 1'b0, 1'b1, 32'h0BAD_0BAD, 0);
      end
      tick();
      bus.host_wr_req = 1'b0;
    end
    bus.ctrl_busy = 1'b0;
  endtask

  // Controller model: n byte pulses two cycles apart, optional reset after byte rst_at.
  task automatic xfer(input int n, input logic [7:0] seed, input bit fb_last, input int rst_at);
    logic [7:0] d;
    while (cyc < m_exec_at) tick();
    tick();
    if (m_op) chk("outgoing_first", 32'(bus.ctrl_outgoing_byte), 32'(m_mem[0]));
    for (int i = 0; i < n; i++) begin
      d = (i < int'(BB)) ? 8'(i + int'(seed)) : 8'hEE;
      bus.ctrl_finished_byte = 1'b1;
      bus.ctrl_incoming_byte = d;
      if (fb_last && i == n - 1) begin
        bus.ctrl_finished_block = 1'b1;
        end_block(cyc, n);
      end
      if (!m_op && i < int'(BB)) m_mem[i] = d;
      if (i == 10) begin
        bus.buf_we    = 1'b1;
        bus.buf_addr  = 9'd450;
        bus.buf_wdata = 8'h5C;
      end
      tick();
      bus.ctrl_finished_byte  = 1'b0;
      bus.ctrl_finished_block = 1'b0;
      bus.buf_we              = 1'b0;
      if (rst_at == i + 1) begin
        btn = 1'b1;
        m_to = cyc + 1;
        m_done_at = -1;
        m_exec_at = -1;
        tick();
        btn = 1'b0;
        chk("rst_mid_busy", 32'(bus.host_busy), 32'd0);
        chk("rst_mid_execute", 32'(bus.ctrl_execute), 32'd0);
        chk("rst_mid_block_address", bus.ctrl_block_address, 32'd0);
        return;
      end
      tick();
      if (m_op)
        chk("outgoing_byte", 32'(bus.ctrl_outgoing_byte),
            32'(m_mem[(i + 1 < int'(BB)) ? i + 1 : int'(BB) - 1]));
    end
    if (!fb_last) begin
      bus.ctrl_finished_block = 1'b1;
      end_block(cyc, n);
      tick();
      bus.ctrl_finished_block = 1'b0;
    end
    while (cyc <= m_done_at) tick();
  endtask

  task automatic check_buf(input int a, input logic [7:0] exp);
    bus.buf_addr = PW'(a);
    tick();
    chk("buf_rdata_literal", 32'(bus.buf_rdata), 32'(exp));
  endtask

  task automatic sweep();
    for (int a = 0; a < int'(BB); a++) begin
      bus.buf_addr = PW'(a);
      tick();
    end
  endtask

  task automatic expect_result(input string name, input int d0, input int e0, input int err);
    chk({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_error_count"}, 32'(err_cnt - e0), 32'(err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, x0;
    for (int i = 0; i < int'(BB); i++) m_mem[i] = 'x;
    bus.host_rd_req = 0; bus.host_wr_req = 0; bus.host_addr = '0;
    bus.buf_addr = '0; bus.buf_wdata = '0; bus.buf_we = 0;
    bus.ctrl_incoming_byte = '0; bus.ctrl_finished_byte = 0;
    bus.ctrl_finished_block = 0; bus.ctrl_busy = 0;

    repeat (5) tick();
    btn = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", 32'(bus.host_busy), 32'd0);
    chk("reset_done", 32'(bus.host_done), 32'd0);
    chk("reset_error", 32'(bus.host_error), 32'd0);
    chk("reset_execute", 32'(bus.ctrl_execute), 32'd0);
    chk("reset_op_code", 32'(bus.ctrl_op_code), 32'd0);
    chk("reset_block_address", bus.ctrl_block_address, 32'd0);
    chk("reset_outgoing", 32'(bus.ctrl_outgoing_byte), 32'd0);
    chk("reset_rdata", 32'(bus.buf_rdata), 32'd0);
    tick();

    // Full read, bytes i & 0xFF
    d0 = done_cnt; e0 = err_cnt; x0 = exec_cnt;
    req(1, 0, 32'h0000_1234, 0);
    xfer(512, 8'h00, 0, 0);
    chk("read_exec_count", 32'(exec_cnt - x0), 32'd1);
    expect_result("read", d0, e0, 0);
    check_buf(37, 8'h25);
    check_buf(511, 8'hFF);
    sweep();

    // Host fill then full write
    for (int i = 0; i < int'(BB); i++) begin
      bus.buf_addr = PW'(i);
      bus.buf_wdata = 8'(255 - i);
      bus.buf_we = 1'b1;
      tick();
    end
    bus.buf_we = 1'b0;
    check_buf(0, 8'hFF);
    check_buf(300, 8'hD3);
    d0 = done_cnt; e0 = err_cnt;
    req(0, 1, 32'h0000_0012, 0);
    chk("write_op_code", 32'(bus.ctrl_op_code), 32'd1);
    xfer(512, 8'h00, 0, 0);
    expect_result("write", d0, e0, 0);

    // Short block; the buf_we during the transfer must be ignored
    d0 = done_cnt; e0 = err_cnt;
    req(1, 0, 32'h0000_0100, 0);
    xfer(300, 8'h11, 0, 0);
    expect_result("short", d0, e0, 1);
    check_buf(299, 8'h3C);
    check_buf(300, 8'hD3);
    check_buf(450, 8'h3D);

    // Long block, block end coincident with the last byte
    d0 = done_cnt; e0 = err_cnt;
    req(1, 0, 32'h0000_0200, 0);
    xfer(520, 8'h40, 1, 0);
    expect_result("long", d0, e0, 1);
    check_buf(0, 8'h40);
    check_buf(7, 8'h47);

    // Exact block, block end coincident with byte 512
    d0 = done_cnt; e0 = err_cnt;
    req(1, 0, 32'h0000_0201, 0);
    xfer(512, 8'h01, 1, 0);
    expect_result("coincident", d0, e0, 0);

    // Controller busy for 10 cycles, write request injected while waiting
    d0 = done_cnt; e0 = err_cnt; x0 = exec_cnt;
    req(1, 0, 32'h0000_0300, 10);
    xfer(512, 8'h77, 0, 0);
    chk("contention_exec_count", 32'(exec_cnt - x0), 32'd1);
    expect_result("contention", d0, e0, 0);

    // Simultaneous read and write: read wins
    d0 = done_cnt; e0 = err_cnt;
    req(1, 1, 32'h0000_ABCD, 0);
    chk("simul_op_code", 32'(bus.ctrl_op_code), 32'd0);
    xfer(512, 8'h5A, 0, 0);
    expect_result("simul", d0, e0, 0);
    check_buf(1, 8'h5B);

    // Reset after byte 100, then a clean read
    req(1, 0, 32'h0000_0400, 0);
    xfer(512, 8'h33, 0, 100);
    check_buf(99, 8'h96);
    check_buf(100, 8'hBE);
    d0 = done_cnt; e0 = err_cnt;
    req(1, 0, 32'h0000_0401, 0);
    xfer(512, 8'h99, 0, 0);
    expect_result("after_reset", d0, e0, 0);
    check_buf(10, 8'hA3);
    sweep();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
